fifo_access_ctrl: RTL
=====================

# fifo_access_ctrl

Access controller for the core's shared FIFO buffer (single write port, single read port; write wins when both are enabled in one cycle). It arbitrates `kReqNum` producers round-robin onto the write port and one consumer onto the read port. It guarantees that write and read are never enabled in the same cycle, alternating between them under contention. It also sequences a flush that drains the FIFO without resetting it.

## Interface
- `kWidth`, 32, entry width in bits
- `kAddrWidth`, 4, FIFO address width; depth = 2^kAddrWidth
- `kReqNum`, 4, number of producers (≥2)
- `clk`  in  1  clock; all logic on posedge
- `rst`  in  1  reset; **synchronous, active-low**
- `push_valid`  in  kReqNum  per-producer push request
- `push_data`  in  kReqNum*kWidth  producer i occupies bits [i*kWidth +: kWidth]
- `push_ready`  out  kReqNum  one-hot (or zero) write grant; transfer when valid&ready
- `pop_req`  in  1  consumer read request (level)
- `pop_valid`  out  1  registered; pop_data valid this cycle
- `pop_data`  out  kWidth  registered popped entry
- `flush`  in  1  request to drain the FIFO
- `flush_done`  out  1  one-cycle pulse when drain completes
- `count`  out  kAddrWidth+1  current occupancy, 0..2^kAddrWidth
- `fifo_write_en`, `fifo_write_data`  out  1, kWidth  to FIFO write port
- `fifo_read_en`  out  1  to FIFO read port
- `fifo_read_data`  in  kWidth  from FIFO; valid combinationally while fifo_read_en=1
- `fifo_full`, `fifo_empty`  in  1, 1  FIFO status

## Operation
- The FSM has two states, RUN and FLUSH.
- **Eligibility in RUN with flush=0:**
  - The write side is eligible when any push_valid=1 and fifo_full=0.
  - The read side is eligible when pop_req=1 and fifo_empty=0.
- **Read/write contention:**
  - A 1-bit `prio_read` register decides the winner; its reset value is 0 (write first).
  - When both sides are eligible, the prio side wins and prio_read toggles.
  - When exactly one side is eligible, it wins and prio_read is unchanged.
- **Producer arbitration:**
  - A round-robin pointer `rr_ptr` (reset 0) selects among producers.
  - The grant goes to the first i with push_valid[i]=1, searching rr_ptr, rr_ptr+1, … mod kReqNum.
  - After a write grant to i, rr_ptr ← (i+1) mod kReqNum. It is unchanged otherwise.
- **Write win:**
  - push_ready[i]=1, fifo_write_en=1, fifo_write_data=push_data[i], all combinational in the same cycle.
  - push_ready is 0 for every non-granted producer.
- **Read win:** fifo_read_en=1. Next cycle, pop_data ← fifo_read_data and pop_valid=1 for exactly one cycle.
- **Mutual exclusion:** fifo_write_en & fifo_read_en = 0 in every cycle, including during FLUSH.
- **count:**
  - +1 on a write cycle, −1 on a read cycle, including flush reads.
  - It never exceeds 2^kAddrWidth and never underflows, because full/empty gating prevents it.
- **flush=1 in RUN:**
  - No grants that cycle (push_ready=0, fifo_read_en=0).
  - Next state is FLUSH.
- **FLUSH:**
  - push_ready=0.
  - pop_req is ignored and pop_valid stays 0.
  - If fifo_empty=0: fifo_read_en=1 and the data is discarded.
  - If fifo_empty=1: next state is RUN and flush_done=1 in the next cycle.
  - flush is ignored while in FLUSH.
- Flushing an already-empty FIFO takes FLUSH for 1 cycle, then flush_done.

## Timing
- Reset (rst=0 at posedge) forces:
  - state=RUN, rr_ptr=0, prio_read=0, count=0;
  - pop_valid=0, pop_data=0, flush_done=0.
- Combinational outputs are 0 during the reset cycle. Reset mid-FLUSH aborts the drain and produces no flush_done.
- Push latency is 0: handshake and FIFO write happen in the same cycle.
- Pop latency is 1 cycle, from the read-grant cycle to pop_valid.
- Flush latency with N entries: flush cycle, then N FLUSH read cycles, then 1 FLUSH empty cycle. flush_done asserts N+2 cycles after flush is sampled.
- Full and empty are taken from the FIFO, which updates one cycle after a write or read; the controller relies on them directly.
- Back-to-back operation: under sustained contention, writes and reads alternate every cycle (W,R,W,R…).

## Test plan
Default parameters for all scenarios: kWidth=8, kAddrWidth=2, kReqNum=4.

1. Reset, then idle:
   - all outputs 0, count=0;
   - push_valid=4'b0001 with data 0x11 → push_ready=0001, fifo_write_en=1 same cycle, count=1 next cycle.
2. Round-robin with push_valid=4'b1111 held, pop_req=0, FIFO empty:
   - grants 0,1,2,3 in order over 4 cycles, with data 0xA0..0xA3;
   - then fifo_full=1 → push_ready=0, count=4.
3. Contention: FIFO holds 2 entries, pop_req=1 and push_valid=4'b0100 held:
   - fifo_write_en, fifo_read_en alternate W,R,W,R starting with W;
   - never both high;
   - pop_data follows FIFO order with pop_valid 1 cycle after each read.
4. Empty read: FIFO empty, pop_req=1 for 3 cycles → fifo_read_en=0, pop_valid=0, count=0.
5. Flush with 3 entries while pop_req=1 and push_valid=4'b1111:
   - no push_ready during the drain, 3 discard reads, pop_valid stays 0;
   - flush_done pulses exactly 5 cycles after flush is sampled;
   - count=0, and RUN grants resume the next cycle.
6. Assert rst=0 during the second FLUSH read → next cycle state=RUN, count=0, flush_done=0, rr_ptr=0, prio_read=0.

Source files
------------

// File: rtl/fifo_access_ctrl.sv
// rtl/fifo_access_ctrl.sv - shared FIFO access controller: round-robin producers, one consumer, flush sequencing
//
// Ports:
//   clk, rst           clock and synchronous active-low reset
//   push_valid/data    per-producer write requests; producer i data at [i*kWidth +: kWidth]
//   push_ready         one-hot (or zero) write grant, combinational
//   pop_req            consumer read request (level)
//   pop_valid/data     registered read result, one cycle after the read grant
//   flush, flush_done  drain request and one-cycle completion pulse
//   count              controller-tracked occupancy
//   fifo_*             FIFO write port, read port and status
module fifo_access_ctrl #(
    parameter int kWidth     = 32,
    parameter int kAddrWidth = 4,
    parameter int kReqNum    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [kReqNum-1:0]        push_valid,
    input  logic [kReqNum*kWidth-1:0] push_data,
    output logic [kReqNum-1:0]        push_ready,
    input  logic                      pop_req,
    output logic                      pop_valid,
    output logic [kWidth-1:0]         pop_data,
    input  logic                      flush,
    output logic                      flush_done,
    output logic [kAddrWidth:0]       count,
    output logic                      fifo_write_en,
    output logic [kWidth-1:0]         fifo_write_data,
    output logic                      fifo_read_en,
    input  logic [kWidth-1:0]         fifo_read_data,
    input  logic                      fifo_full,
    input  logic                      fifo_empty
);

    localparam int kPtrW = (kReqNum > 1) ? $clog2(kReqNum) : 1;
    localparam int kCntW = kAddrWidth + 1;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]       state;
    logic [kPtrW-1:0] rr_ptr;
    logic             prio_read;

    logic             in_run;
    logic             write_elig;
    logic             read_elig;
    logic             write_win;
    logic             read_win;
    logic             drain_read;
    logic             grant_found;
    logic [kPtrW-1:0] grant_idx;
    logic [kPtrW-1:0] cand;
    logic [kPtrW-1:0] rr_next;

    // Grants only happen in RUN on a cycle without a flush request; every
    // combinational output is also forced low while reset is asserted.
    assign in_run     = rst && (state == ST_RUN) && !flush;
    assign write_elig = in_run && (|push_valid) && !fifo_full;
    assign read_elig  = in_run && pop_req && !fifo_empty;
    assign write_win  = write_elig && (!read_elig || !prio_read);
    assign read_win   = read_elig && (!write_elig || prio_read);
    assign drain_read = rst && (state == ST_FLUSH) && !fifo_empty;

    // First requesting producer at or after rr_ptr, wrapping modulo kReqNum.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr_ptr;
        cand        = rr_ptr;
        for (int k = 0; k < kReqNum; k++) begin
            cand = kPtrW'((int'(rr_ptr) + k) % kReqNum);
            if (!grant_found && push_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign rr_next = (int'(grant_idx) == kReqNum - 1) ? '0 : grant_idx + kPtrW'(1);

    assign push_ready      = write_win ? (kReqNum'(1) << grant_idx) : '0;
    assign fifo_write_en   = write_win;
    assign fifo_write_data = write_win ? push_data[int'(grant_idx)*kWidth +: kWidth] : '0;
    // write_win and read_win are exclusive by construction, and drain_read
    // only exists outside RUN, so the FIFO never sees both enables.
    assign fifo_read_en    = read_win || drain_read;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_RUN;
            rr_ptr     <= '0;
            prio_read  <= 1'b0;
            count      <= '0;
            pop_valid  <= 1'b0;
            pop_data   <= '0;
            flush_done <= 1'b0;
        end else begin
            if (write_win) begin
                rr_ptr <= rr_next;
                count  <= count + kCntW'(1);
            end else if (fifo_read_en) begin
                count  <= count - kCntW'(1);
            end

            // Priority flips only when both sides actually competed.
            if (write_elig && read_elig) begin
                prio_read <= !prio_read;
            end

            // Drain reads are discarded: they never reach pop_valid/pop_data.
            pop_valid <= read_win;
            if (read_win) begin
                pop_data <= fifo_read_data;
            end

            flush_done <= (state == ST_FLUSH) && fifo_empty;

            case (state)
                ST_RUN:   if (flush) state <= ST_FLUSH;
                ST_FLUSH: if (fifo_empty) state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

endmodule
